// File: rtl/seq_alu_accumulator.sv
// seq_alu_accumulator: multi-cycle ALU that writes a 2*WIDTH-bit accumulator.
// Single-cycle ops update acc on the accept edge. MUL, DIV and MOD iterate one
// bit per clock and update acc WIDTH+1 edges after the accept edge.
// Optional macro SEQ_ALU_SIGNED_EN: MUL/DIV/MOD use two's-complement operands.
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// start while busy=1 is dropped, not queued. done pulses for exactly one cycle
// on the edge that writes acc and is never high together with busy.
module seq_alu_accumulator #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op_code,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 b_sel,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 busy,
    output logic                 done,
    output logic                 carry,
    output logic                 err_ovf,
    output logic                 err_div0,
    output logic [1:0]           state_dbg
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_MOD  = 4'd1,  OP_DIV  = 4'd2,  OP_RST  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_NAND = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8,  OP_NOR  = 4'd9,  OP_XOR  = 4'd10, OP_XNOR = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12, OP_NOP  = 4'd13, OP_ZERO = 4'd14, OP_PSET = 4'd15;

    localparam logic [WIDTH-1:0] ZERO_W = '0;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi;      // MUL: product high half; DIV/MOD: partial remainder
    logic [WIDTH-1:0]   lo;      // MUL: multiplier / product low half; DIV/MOD: dividend -> quotient

    logic               accept;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_ovf;
    logic [2*WIDTH-1:0] sc_res;
    logic               sc_carry;
    logic               sc_ovf;
    logic               sc_div0;
    logic               sc_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] fin_res;

    assign accept    = start && (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign op_b      = b_sel ? acc[WIDTH-1:0] : in_b;
    assign add_sum   = {1'b0, in_a} + {1'b0, op_b};
    assign sub_sum   = {1'b0, in_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef SEQ_ALU_SIGNED_EN
    logic acc_neg;
    logic neg_q;
    assign mag_a   = in_a[WIDTH-1] ? -in_a : in_a;
    assign mag_b   = op_b[WIDTH-1] ? -op_b : op_b;
    assign div_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
    assign acc_neg = (op_code == OP_MOD) ? in_a[WIDTH-1] : (in_a[WIDTH-1] ^ op_b[WIDTH-1]);

    // Result sign captured at accept; the iteration works on magnitudes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 neg_q <= 1'b0;
        else if (accept && sc_iter) neg_q <= acc_neg;
    end
`else
    assign mag_a   = in_a;
    assign mag_b   = op_b;
    assign div_ovf = 1'b0;
`endif

    // Single-cycle result and flags, plus the decision to start iterating
    always_comb begin
        sc_res   = acc;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_div0  = 1'b0;
        sc_iter  = 1'b0;
        case (op_code)
            OP_ADD: begin
                sc_res   = {ZERO_W, add_sum[WIDTH-1:0]};
                sc_carry = add_sum[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = {ZERO_W, sub_sum[WIDTH-1:0]};
                sc_carry = sub_sum[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  sc_res = {ZERO_W, in_a & op_b};
            OP_OR:   sc_res = {ZERO_W, in_a | op_b};
            OP_NAND: sc_res = {ZERO_W, ~(in_a & op_b)};
            OP_NOR:  sc_res = {ZERO_W, ~(in_a | op_b)};
            OP_XOR:  sc_res = {ZERO_W, in_a ^ op_b};
            OP_XNOR: sc_res = {ZERO_W, ~(in_a ^ op_b)};
            OP_NOT:  sc_res = {ZERO_W, ~in_a};
            OP_RST, OP_ZERO: sc_res = '0;
            OP_PSET: sc_res = '1;
            OP_MUL:  sc_iter = 1'b1;
            OP_DIV, OP_MOD: begin
                if (op_b == ZERO_W) begin
                    sc_res  = '1;
                    sc_div0 = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                    sc_ovf  = div_ovf;
                end
            end
            default: sc_res = acc;  // NO-OP keeps acc
        endcase
    end

    // One shift-add or restoring-subtract step per ITER cycle
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};

    // Final result, with the sign fix-up applied when signed ops are enabled
    always_comb begin
        fin_res = {hi, lo};
`ifdef SEQ_ALU_SIGNED_EN
        case (op_q)
            OP_DIV:  fin_res = {{WIDTH{(neg_q ? -lo : lo) >> (WIDTH-1) != ZERO_W}}, (neg_q ? -lo : lo)};
            OP_MOD:  fin_res = {{WIDTH{(neg_q ? -hi : hi) >> (WIDTH-1) != ZERO_W}}, (neg_q ? -hi : hi)};
            default: fin_res = neg_q ? -{hi, lo} : {hi, lo};
        endcase
`else
        case (op_q)
            OP_DIV:  fin_res = {ZERO_W, lo};
            OP_MOD:  fin_res = {ZERO_W, hi};
            default: fin_res = {hi, lo};
        endcase
`endif
    end

    // Control FSM, accumulator, flags and iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            done     <= 1'b0;
            carry    <= 1'b0;
            err_ovf  <= 1'b0;
            err_div0 <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        carry    <= sc_carry;
                        err_ovf  <= sc_ovf;
                        err_div0 <= sc_div0;
                        if (sc_iter) begin
                            state <= ITER;
                            cnt   <= '0;
                            op_q  <= op_code;
                            b_q   <= mag_b;
                            hi    <= '0;
                            lo    <= mag_a;
                        end else begin
                            acc  <= sc_res;
                            done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (op_q == OP_MUL) begin
                        hi <= mul_sum[WIDTH:1];
                        lo <= {mul_sum[0], lo[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH+1]) begin
                        hi <= div_diff[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi <= div_shift[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    acc   <= fin_res;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_accumulator.sv
`timescale 1ns/1ps
module tb_seq_alu_accumulator;
  localparam int W  = 16;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic b_sel = 1'b0;
  logic [3:0] op_code = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W2-1:0] acc;
  logic busy, done, carry, err_ovf, err_div0;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  seq_alu_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_code(op_code),
    .in_a(in_a), .in_b(in_b), .b_sel(b_sel), .acc(acc), .busy(busy),
    .done(done), .carry(carry), .err_ovf(err_ovf), .err_div0(err_div0),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void alu_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W2-1:0] cur, output logic [W2-1:0] res,
                                    output logic c, output logic v, output logic z, output logic it);
    longint ua, ub, sa, sb, t;
    logic [W-1:0] rw;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; c = 1'b0; v = 1'b0; z = 1'b0; it = 1'b0;
    case (op)
      4'd0: begin
        t = ua + ub; rw = W'(t); res = W2'(rw);
        c = (t >= (longint'(1) << W));
        v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'd8: begin
        t = ua - ub; rw = W'(t); res = W2'(rw);
        c = (ua >= ub);
        v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      4'd5:  begin rw = a & b;    res = W2'(rw); end
      4'd6:  begin rw = a | b;    res = W2'(rw); end
      4'd7:  begin rw = ~(a & b); res = W2'(rw); end
      4'd9:  begin rw = ~(a | b); res = W2'(rw); end
      4'd10: begin rw = a ^ b;    res = W2'(rw); end
      4'd11: begin rw = ~(a ^ b); res = W2'(rw); end
      4'd12: begin rw = ~a;       res = W2'(rw); end
      4'd3, 4'd14: res = '0;
      4'd15: res = '1;
      4'd13: res = cur;
      4'd4: begin
        it = 1'b1;
`ifdef SEQ_ALU_SIGNED_EN
        t = sa * sb;
`else
        t = ua * ub;
`endif
        res = W2'(t);
      end
      default: begin  // 1 MOD, 2 DIV
        if (b == '0) begin
          res = '1; z = 1'b1;
        end else begin
          it = 1'b1;
`ifdef SEQ_ALU_SIGNED_EN
          t = (op == 4'd2) ? sa / sb : sa % sb;
          rw = W'(t);
          res = {{W{rw[W-1]}}, rw};
          v = (sa == -32768) && (sb == -1);
`else
          t = (op == 4'd2) ? ua / ub : ua % ub;
          rw = W'(t);
          res = W2'(rw);
`endif
        end
      end
    endcase
  endfunction

  logic [W2-1:0] m_acc, m_pend;
  logic m_done, m_carry, m_ovf, m_div0;
  int m_left;

  always @(posedge clk or negedge rst_n) begin
    logic [W2-1:0] r;
    logic c, v, z, it;
    logic [W-1:0] bb;
    if (!rst_n) begin
      m_acc = '0; m_pend = '0; m_done = 0; m_carry = 0; m_ovf = 0; m_div0 = 0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_acc = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        bb = b_sel ? m_acc[W-1:0] : in_b;
        alu_model(op_code, in_a, bb, m_acc, r, c, v, z, it);
        m_carry = c; m_ovf = v; m_div0 = z;
        if (it) begin
          m_pend = r;
          m_left = W + 1;
        end else begin
          m_acc = r;
          m_done = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("acc", acc, m_acc);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_done);
      chk("carry", carry, m_carry);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_div0", err_div0, m_div0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic bs);
    start = 1'b1; op_code = op; in_a = a; in_b = b; b_sel = bs;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, n < 64, 1'b1);
  endtask

  task automatic lit(input string name, input logic [W2-1:0] exp);
    chk({name, "_dut"}, acc, exp);
    chk({name, "_model"}, m_acc, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int nb;
    repeat (2) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {carry, err_ovf, err_div0}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Abort a MUL with reset after five iterations
    do_op(4'd0, 16'd6, 16'd9, 1'b0);
    lit("pre_abort", 32'h0000_000F);
    do_op(4'd4, 16'h1234, 16'h0100, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_acc", acc, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd0, 16'd6, 16'd9, 1'b0);
    lit("add_6_9", 32'h0000_000F);
    chk("add_done", done, 1);
    chk("add_carry", carry, 0);
    do_op(4'd8, 16'd6, 16'd9, 1'b0);
    lit("sub_6_9", 32'h0000_FFFD);
    chk("sub_flags", {carry, err_ovf}, 2'b00);
    do_op(4'd0, 16'h7FFF, 16'h0001, 1'b0);
    lit("add_ovf", 32'h0000_8000);
    chk("add_ovf_flag", err_ovf, 1);
    do_op(4'd8, 16'h8000, 16'h0001, 1'b0);
    lit("sub_ovf", 32'h0000_7FFF);
    chk("sub_ovf_flags", {carry, err_ovf}, 2'b11);

    // MUL with latency count and an ignored start while busy
    do_op(4'd4, 16'h1234, 16'h0100, 1'b0);
    nb = 1;
    for (int i = 0; i < 40; i++) begin
      if (nb == 3) begin
        start = 1'b1; op_code = 4'd15; in_a = 16'h0; in_b = 16'h0; b_sel = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    start = 1'b0;
    chk("mul_busy_cycles", nb, 17);
    chk("mul_done", done, 1);
    lit("mul_1234_0100", 32'h0012_3400);

    do_op(4'd2, 16'd100, 16'd7, 1'b0);  wait_done("div"); lit("div_100_7", 32'd14);
    @(negedge clk);
    do_op(4'd1, 16'd100, 16'd7, 1'b0);  wait_done("mod"); lit("mod_100_7", 32'd2);
    @(negedge clk);
    do_op(4'd2, 16'd5, 16'd0, 1'b0);
    lit("div0", 32'hFFFF_FFFF);
    chk("div0_flag", err_div0, 1);
    chk("div0_done", done, 1);
    do_op(4'd15, 16'h0, 16'h0, 1'b0);   lit("preset", 32'hFFFF_FFFF);
    do_op(4'd3, 16'h0, 16'h0, 1'b0);    lit("reset_op", 32'h0);

    // Feedback chain, back-to-back
    do_op(4'd0, 16'd1, 16'hAAAA, 1'b1); lit("fb1", 32'd1); chk("fb1_done", done, 1);
    do_op(4'd0, 16'd1, 16'hAAAA, 1'b1); lit("fb2", 32'd2); chk("fb2_done", done, 1);
    do_op(4'd0, 16'd1, 16'hAAAA, 1'b1); lit("fb3", 32'd3); chk("fb3_done", done, 1);
    do_op(4'd13, 16'h5555, 16'h5555, 1'b0); lit("nop", 32'd3); chk("nop_done", done, 1);

    // Bitwise ops
    do_op(4'd5,  16'hF0F0, 16'h0FF0, 1'b0); lit("and",  32'h0000_00F0);
    do_op(4'd6,  16'hF0F0, 16'h0FF0, 1'b0); lit("or",   32'h0000_FFF0);
    do_op(4'd7,  16'hF0F0, 16'h0FF0, 1'b0); lit("nand", 32'h0000_FF0F);
    do_op(4'd9,  16'hF0F0, 16'h0FF0, 1'b0); lit("nor",  32'h0000_000F);
    do_op(4'd10, 16'hF0F0, 16'h0FF0, 1'b0); lit("xor",  32'h0000_FF00);
    do_op(4'd11, 16'hF0F0, 16'h0FF0, 1'b0); lit("xnor", 32'h0000_00FF);
    do_op(4'd12, 16'h1234, 16'h0000, 1'b0); lit("not",  32'h0000_EDCB);
    do_op(4'd14, 16'h1234, 16'h0000, 1'b0); lit("zero", 32'h0);
    do_op(4'd8,  16'd9, 16'd6, 1'b0);       lit("sub_9_6", 32'd3); chk("sub_9_6_carry", carry, 1);

    // DIV with B taken from the accumulator
    do_op(4'd0, 16'd3, 16'd4, 1'b0);        lit("seven", 32'd7);
    do_op(4'd2, 16'd100, 16'h0000, 1'b1);   wait_done("div_fb"); lit("div_fb", 32'd14);
    @(negedge clk);

    // Signedness-dependent vectors
    do_op(4'd2, 16'hFFF9, 16'd2, 1'b0); wait_done("sdiv"); @(negedge clk);
    do_op(4'd1, 16'hFFF9, 16'd2, 1'b0); wait_done("smod"); @(negedge clk);
    do_op(4'd4, 16'hFFFD, 16'd5, 1'b0); wait_done("smul"); @(negedge clk);
`ifdef SEQ_ALU_SIGNED_EN
    lit("smul_m3_5", 32'hFFFF_FFF1);
`else
    lit("umul_fffd_5", 32'h0004_FFF1);
`endif
    do_op(4'd2, 16'h8000, 16'hFFFF, 1'b0); wait_done("sovf");
`ifdef SEQ_ALU_SIGNED_EN
    lit("sdiv_ovf", 32'hFFFF_8000);
    chk("sdiv_ovf_flag", err_ovf, 1);
`else
    lit("udiv_8000_ffff", 32'h0);
    chk("udiv_ovf_flag", err_ovf, 0);
`endif
    @(negedge clk);
    do_op(4'd1, 16'hFFF9, 16'd2, 1'b0); wait_done("smod2");
`ifdef SEQ_ALU_SIGNED_EN
    lit("smod_m7_2", 32'hFFFF_FFFF);
`else
    lit("umod_fff9_2", 32'd1);
`endif
    @(negedge clk);
    do_op(4'd2, 16'hFFF9, 16'd2, 1'b0); wait_done("sdiv2");
`ifdef SEQ_ALU_SIGNED_EN
    lit("sdiv_m7_2", 32'hFFFF_FFFD);
`else
    lit("udiv_fff9_2", 32'h0000_7FFC);
`endif
    @(negedge clk);
    do_op(4'd4, 16'hFFFF, 16'hFFFF, 1'b0); wait_done("mul_max");
`ifdef SEQ_ALU_SIGNED_EN
    lit("smul_m1_m1", 32'h0000_0001);
`else
    lit("umul_max", 32'hFFFE_0001);
`endif
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu_accumulator.md
Name: seq_alu_accumulator

Overview:
- Parametrised multi-cycle ALU with a 2*WIDTH-bit accumulator register and a start/busy/done handshake.
- Same 4-bit op_code map as the existing combinational ALU board.
- Multiply, divide and modulo are iterative (one bit per clock); all other ops complete in one cycle.
- Operand B is either an external bus or the accumulator's low half, so chained/feedback calculations run without testbench glue.

Parameters:
- WIDTH, 16, operand width in bits (>=4); accumulator and result are 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- op_code  in  4  operation; sampled at accept.
- in_a  in  WIDTH  operand A; sampled at accept.
- in_b  in  WIDTH  external operand B; sampled at accept.
- b_sel  in  1  0: B=in_b, 1: B=acc[WIDTH-1:0]; sampled at accept.
- acc  out  2*WIDTH  accumulator / result register.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse on the edge acc is updated.
- carry  out  1  add carry-out / sub no-borrow.
- err_ovf  out  1  signed add/sub overflow (plus signed-div overflow, see Optional Feature).
- err_div0  out  1  divide or modulo by zero.

Behaviour:
- Reset (async, rst_n=0):
  - acc=0, busy=0, done=0, carry=0, err_ovf=0, err_div0=0, FSM=IDLE.
  - Asserting rst_n mid-operation aborts it; no done pulse.
- FSM states: IDLE, ITER, FIN.
- Accept: clock edge where start=1 and state=IDLE. Operands, op_code and b_sel are latched. Flags clear to 0 and are then set by this op only. Flags are held until the next accept.
- Single-cycle ops:
  - Take effect on the accept edge: acc written, done=1 for one cycle, busy stays 0, state stays IDLE.
  - Back-to-back starts are accepted every cycle.
- op_code map (W=WIDTH; results zero-extended to 2W unless stated):
  - 0 ADD: A+B; carry = bit W of the sum; err_ovf = signed overflow.
  - 8 SUB: A+~B+1; carry = no-borrow; err_ovf = signed overflow.
  - 5 AND, 6 OR, 7 NAND, 9 NOR, 10 XOR, 11 XNOR: bitwise on W bits.
  - 12 NOT: ~A.
  - 3 RESET and 14 ZERO: acc=0.
  - 15 PRESET: acc = all ones (2W bits).
  - 13 NO-OP: acc unchanged; done still pulses.
  - 4 MUL: 2W-bit product, shift-add.
  - 2 DIV: quotient; 1 MOD: remainder; restoring division.
- Iterative ops (4, 2, 1) with divisor nonzero:
  - Accept edge: state -> ITER, busy=1, counter=0.
  - One partial step per clock for W clocks, then state -> FIN.
  - FIN edge: acc written, done=1, busy=0, state -> IDLE.
  - acc is updated exactly W+1 edges after the accept edge; busy is high for W+1 cycles.
  - acc holds its old value until the FIN edge; internal partials go to separate registers.
- Divide by zero (op 2 or 1 with B=0):
  - No iteration; handled like a single-cycle op.
  - acc = all ones, err_div0=1, done pulses on the accept edge.
- start while busy=1: ignored; it is not queued and latched operands are not disturbed.
- b_sel=1 uses acc[W-1:0] as it stands at the accept edge, i.e. the result of the previous op.
- done never coincides with busy=1.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_EN.
- Defined: MUL/DIV/MOD treat A and B as two's complement.
  - Magnitudes are iterated and the sign is fixed in FIN; no extra latency.
  - Product is signed 2W bits.
  - Quotient truncates toward zero; remainder takes the dividend's sign; both sign-extended to 2W.
  - Most-negative / -1: quotient = most-negative sign-extended, remainder 0, err_ovf=1.
- Undefined: all three ops are unsigned and zero-extended; err_ovf is never set by them.

Test Plan:
- Reset: start MUL, pull rst_n low at iteration 5 -> acc=0, busy=0, no done; next ADD 6+9 behaves normally.
- WIDTH=16, ADD in_a=6 in_b=9 -> acc=0x0000000F, done next edge, carry=0. Then SUB 6-9 -> acc=0x0000FFFD, carry=0, err_ovf=0. Then ADD 0x7FFF+1 -> err_ovf=1.
- MUL 0x1234*0x0100 -> busy high 17 cycles, acc=0x00123400 on edge 17. A start pulse during busy is ignored and acc is unchanged.
- DIV 100/7 -> acc=14. MOD 100/7 -> acc=2. DIV 5/0 -> acc=0xFFFFFFFF, err_div0=1, done on the accept edge. PRESET -> 0xFFFFFFFF. RESET -> 0.
- Feedback: RESET, then ADD in_a=1 b_sel=1 on three consecutive cycles -> acc = 1, 2, 3 with done every cycle. NO-OP -> acc stays 3.
- SEQ_ALU_SIGNED_EN defined:
  - DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF; MUL -3*5 -> 0xFFFFFFF1.
  - 0x8000 / 0xFFFF -> acc=0xFFFF8000, err_ovf=1.
  - Same vectors undefined: unsigned results.
